// File: rtl/shift_left_seq_pkg.sv
// Shared constants and state encoding for the iterative left shifter.
package shift_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned SHAMT_W   = 5;
   localparam int unsigned FAST_STEP = 4;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/shift_left_seq_step.sv
// One SHIFT-cycle update of the data/count pair (combinational).
// The four-bit step is compiled in with SHIFT_LEFT_SEQ_FAST_EN.
import shift_pkg::*;

module shift_left_step (
   input  logic [XLEN-1:0]    data,
   input  logic [SHAMT_W-1:0] cnt,
   output logic [XLEN-1:0]    data_nxt,
   output logic [SHAMT_W-1:0] cnt_nxt
);

   always_comb begin
      data_nxt = data;
      cnt_nxt  = cnt;
`ifdef SHIFT_LEFT_SEQ_FAST_EN
      if (cnt >= SHAMT_W'(FAST_STEP)) begin
         data_nxt = {data[XLEN-FAST_STEP-1:0], {FAST_STEP{1'b0}}};
         cnt_nxt  = cnt - SHAMT_W'(FAST_STEP);
      end else if (cnt != '0) begin
         data_nxt = {data[XLEN-2:0], 1'b0};
         cnt_nxt  = cnt - 1'b1;
      end
`else
      if (cnt != '0) begin
         data_nxt = {data[XLEN-2:0], 1'b0};
         cnt_nxt  = cnt - 1'b1;
      end
`endif
   end

endmodule

// File: rtl/shift_left_seq.sv
// Multi-cycle logical left shifter with start/busy/done handshake.
// Optional macro SHIFT_LEFT_SEQ_FAST_EN enables four-bit steps (see shift_left_step).
import shift_pkg::*;

module shift_left_seq (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [XLEN-1:0]    a_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [XLEN-1:0]    c_o
);

   state_t             state, state_nxt;
   logic [XLEN-1:0]    data, step_data;
   logic [SHAMT_W-1:0] cnt, step_cnt;
   logic               load;

   shift_left_step u_step (
      .data     (data),
      .cnt      (cnt),
      .data_nxt (step_data),
      .cnt_nxt  (step_cnt)
   );

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == '0) state_nxt = DONE;
         end
         DONE: begin
            // start in DONE is accepted directly, avoiding an IDLE bubble
            if (start_i) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         data  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            data <= a_i;
            cnt  <= shamt_i;
         end else if (state == SHIFT) begin
            data <= step_data;
            cnt  <= step_cnt;
         end
      end
   end

   assign busy_o = (state == SHIFT);
   assign done_o = (state == DONE);
   assign c_o    = data;

endmodule

// File: tb/tb_shift_left_seq.sv
// Scoreboard bench for shift_left_seq: driver pushes expected result and done cycle,
// monitor pops and compares on every done_o pulse.
module tb_shift_left_seq;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] a_i = '0;
   logic [4:0]  shamt_i = '0;
   logic        busy_o, done_o;
   logic [31:0] c_o;

   typedef struct {
      logic [31:0] c;
      int unsigned cyc;
   } exp_t;

   exp_t        q[$];
   int unsigned cyc = 0;
   int unsigned n_chk = 0;
   int unsigned n_fail = 0;

   shift_left_seq dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .a_i     (a_i),
      .shamt_i (shamt_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .c_o     (c_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc++;

   function automatic int unsigned steps(input int unsigned s);
`ifdef SHIFT_LEFT_SEQ_FAST_EN
      return s / 4 + s % 4;
`else
      return s;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // monitor: every done pulse must match the oldest outstanding request
   always @(negedge clk_i) begin
      exp_t e;
      if (!rst_i && done_o) begin
         if (q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            check("result", c_o, e.c);
            check("done_cycle", cyc, e.cyc);
         end
      end
   end

   // issues start in one cycle; returns at the negedge of the first SHIFT cycle
   task automatic go(input logic [31:0] a, input logic [4:0] s, input logic [31:0] exp_c);
      @(negedge clk_i);
      start_i = 1'b1;
      a_i     = a;
      shamt_i = s;
      q.push_back('{c: exp_c, cyc: cyc + 2 + steps(s)});
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic wait_empty(input int unsigned budget);
      int unsigned k = 0;
      while (q.size() != 0 && k < budget) begin
         @(negedge clk_i);
         k++;
      end
      if (q.size() != 0) begin
         check("timeout", 32'd1, 32'd0);
         q.delete();
      end
      @(negedge clk_i);
   endtask

   initial begin
      logic [31:0] ra;
      logic [4:0]  rs;
      int unsigned k;

      repeat (3) @(negedge clk_i);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      check("rst_c",    c_o, 32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // maximum shift
      go(32'h0000_0001, 5'd31, 32'h8000_0000);
      wait_empty(60);

      // zero shift: busy only in N+1, done in N+2
      go(32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
      check("sh0_busy_n1", {31'd0, busy_o}, 32'd1);
      @(negedge clk_i);
      check("sh0_busy_n2", {31'd0, busy_o}, 32'd0);
      wait_empty(10);

      // back-to-back start in the DONE cycle
      go(32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000);
      k = 0;
      while (!done_o && k < 60) begin
         @(negedge clk_i);
         k++;
      end
      if (!done_o) begin
         check("b2b_wait", 32'd1, 32'd0);
      end else begin
         start_i = 1'b1;
         a_i     = 32'h0000_00F0;
         shamt_i = 5'd4;
         q.push_back('{c: 32'h0000_0F00, cyc: cyc + 2 + steps(4)});
         @(negedge clk_i);
         start_i = 1'b0;
         check("b2b_busy", {31'd0, busy_o}, 32'd1);
      end
      wait_empty(20);

      // start during SHIFT must be ignored
      go(32'h0000_0001, 5'd8, 32'h0000_0100);
      @(negedge clk_i);
      start_i = 1'b1;
      a_i     = 32'h5555_5555;
      shamt_i = 5'd3;
      @(negedge clk_i);
      start_i = 1'b0;
      wait_empty(30);
      repeat (5) @(negedge clk_i);

      // reset mid-operation
      go(32'h0000_0003, 5'd20, 32'h0030_0000);
      repeat (4) @(negedge clk_i);
      rst_i = 1'b1;
      q.delete();
      @(negedge clk_i);
      rst_i = 1'b0;
      check("abort_busy", {31'd0, busy_o}, 32'd0);
      check("abort_done", {31'd0, done_o}, 32'd0);
      check("abort_c",    c_o, 32'd0);
      repeat (40) @(negedge clk_i);

      // random regression
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rs = 5'($urandom_range(0, 31));
         go(ra, rs, ra << rs);
         wait_empty(60);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_left_seq.md
# shift_left_seq

Multi-cycle logical left shifter (SLL/SLLI semantics) for the RV32 execute path. It pairs with the combinational arithmetic right shifter: this block covers the opposite shift direction as an iterative unit. The unit trades latency for area, shifting one bit per cycle, or four bits per cycle when the fast option is compiled in. A start/busy/done handshake lets the surrounding control stall while a shift is in flight.

## Interface
- XLEN, 32: datapath width.
- SHAMT_W, 5: shift-amount width; equals log2(XLEN).
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  request; sampled only in IDLE or DONE.
- a_i  in  XLEN  operand; captured on an accepted start.
- shamt_i  in  SHAMT_W  shift amount; captured on an accepted start.
- busy_o  out  1  high while in SHIFT.
- done_o  out  1  one-cycle pulse; c_o is valid in that cycle.
- c_o  out  XLEN  result register; holds its value until the next accepted start.

## Operation
- States:
  - IDLE: reset state.
  - SHIFT: shifting in progress.
  - DONE: result ready.
- Internal registers: data (XLEN), cnt (SHAMT_W). c_o is driven directly from data.
- Accepted start (start_i=1 in IDLE or DONE):
  - data <= a_i, cnt <= shamt_i, state <= SHIFT.
- SHIFT, cnt != 0: data <= {data[XLEN-2:0],1'b0}, cnt <= cnt-1.
- SHIFT, cnt == 0: state <= DONE; data holds.
- DONE:
  - done_o=1.
  - With start_i=1: accepted (back-to-back operation).
  - With start_i=0: state <= IDLE.
- start_i in SHIFT is ignored; captured operands and cnt are unaffected.
- Zero fill only; shifted-out bits are discarded. shamt_i=0 returns a_i unchanged.
- Reset outputs: busy_o=0, done_o=0, c_o=0. Reset also clears data=0, cnt=0, state=IDLE.
- Reset mid-SHIFT aborts the operation. No done_o pulse follows.

## Timing
- start_i high in cycle N:
  - Cycle N+1: SHIFT, cnt=shamt.
  - done_o high in cycle N+2+steps, with steps = shamt (base build).
- Latency range: 2 cycles (shamt=0) to 33 cycles (shamt=31).
- busy_o:
  - High from N+1 through N+1+steps.
  - Low in DONE and IDLE.
- done_o is registered (a function of state only) and is high for exactly one cycle per accepted start.
- Back-to-back: start_i high in the DONE cycle gives SHIFT in the next cycle. No IDLE bubble.
- Throughput: one result per 2+steps cycles.

## Configuration
- SHIFT_LEFT_SEQ_FAST_EN:
  - Defined: in SHIFT, when cnt >= 4, data <= data<<4 and cnt <= cnt-4. Otherwise the step is one bit. steps = floor(shamt/4) + (shamt mod 4). Latency for shamt=31 is 12 cycles.
  - Undefined: one bit per cycle only; steps = shamt.
- The final result is identical in both builds. Only latency and busy_o duration differ.

## Structure
- Package shift_pkg holds:
  - XLEN and SHAMT_W constants.
  - FAST_STEP=4.
  - Enumerated state_t {IDLE, SHIFT, DONE}.
- One sub-module, shift_left_step (combinational):
  - Inputs: data, cnt.
  - Outputs: next data and next cnt for one SHIFT cycle.
  - The fast-path select is gated by SHIFT_LEFT_SEQ_FAST_EN inside this sub-module.
- The top level holds only the state register, the data/cnt registers and the handshake decode.

## Test plan
- a_i=0x0000_0001, shamt_i=31, start in cycle N:
  - c_o=0x8000_0000 with done_o in N+33 (base build).
  - Same result in N+12 (FAST build).
- a_i=0xDEAD_BEEF, shamt_i=0 -> done_o in N+2, c_o=0xDEAD_BEEF, busy_o high only in N+1.
- a_i=0xFFFF_FFFF, shamt_i=16 -> c_o=0xFFFF_0000. Then start_i held high in the DONE cycle with a_i=0x0000_00F0, shamt_i=4 -> SHIFT next cycle, c_o=0x0000_0F00.
- Mid-operation start ignored:
  - Start with a_i=0x1, shamt_i=8.
  - Pulse start_i with a_i=0x5555_5555 during SHIFT.
  - Required: c_o=0x0000_0100, exactly one done_o pulse.
- Reset mid-operation:
  - Start with shamt_i=20, assert rst_i at N+5.
  - Required next cycle: busy_o=0, done_o=0, c_o=0. No done_o pulse until a new start.
- Random regression:
  - 1000 random a_i/shamt_i pairs.
  - c_o == a_i << shamt_i.
  - done_o latency matches the formula for the compiled build.
